// File: rtl/fft_stage_sequencer.sv
// Stage sequencer for the banked-memory radix-2 FFT: read-side counters,
// delayed write-side copy, start/busy/done handshake and inter-stage drain.
module fft_stage_sequencer #(
  parameter int NUMSTAGES  = 5,
  parameter int BF_LATENCY = 2,
  localparam int CW = NUMSTAGES - 2
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  output logic [CW-1:0] o_counter,
  output logic [2:0]    o_stage_num,
  output logic          o_rd_en,
  output logic [CW-1:0] o_wr_counter,
  output logic [2:0]    o_wr_stage_num,
  output logic          o_wr_en,
  output logic          o_busy,
  output logic          o_done
);

  localparam int DW = (BF_LATENCY > 1) ? $clog2(BF_LATENCY) : 1;
  localparam logic [DW-1:0] DRAIN_LAST = DW'(BF_LATENCY - 1);
  localparam logic [CW-1:0] CNT_LAST   = '1;
  localparam logic [2:0]    STG_LAST   = 3'(NUMSTAGES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_n;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_n;
  logic [2:0]      r_stg;
  logic [2:0]      w_stg_n;
  logic [DW-1:0]   r_drain;
  logic [DW-1:0]   w_drain_n;
  logic            w_rd_en;

  logic            r_pipe_en  [BF_LATENCY];
  logic [CW-1:0]   r_pipe_cnt [BF_LATENCY];
  logic [2:0]      r_pipe_stg [BF_LATENCY];

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_stg   <= '0;
      r_drain <= '0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_stg   <= w_stg_n;
      r_drain <= w_drain_n;
    end
  end

  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_stg_n   = r_stg;
    w_drain_n = r_drain;
    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_state_n = S_RUN;
          w_cnt_n   = '0;
          w_stg_n   = '0;
        end
      end
      S_RUN: begin
        if (r_cnt == CNT_LAST) begin
          w_state_n = S_DRAIN;
          w_cnt_n   = '0;
          w_drain_n = '0;
        end else begin
          w_cnt_n = r_cnt + 1'b1;
        end
      end
      S_DRAIN: begin
        // hold off the next stage until its last butterfly is written back
        if (r_drain == DRAIN_LAST) begin
          w_drain_n = '0;
          if (r_stg < STG_LAST) begin
            w_state_n = S_RUN;
            w_stg_n   = r_stg + 3'd1;
            w_cnt_n   = '0;
          end else begin
            w_state_n = S_DONE;
          end
        end else begin
          w_drain_n = r_drain + 1'b1;
        end
      end
      S_DONE: begin
        w_state_n = S_IDLE;
        w_cnt_n   = '0;
        w_stg_n   = '0;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  assign w_rd_en = (r_state == S_RUN);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < BF_LATENCY; i++) begin
        r_pipe_en[i]  <= 1'b0;
        r_pipe_cnt[i] <= '0;
        r_pipe_stg[i] <= '0;
      end
    end else begin
      r_pipe_en[0]  <= w_rd_en;
      r_pipe_cnt[0] <= r_cnt;
      r_pipe_stg[0] <= r_stg;
      for (int i = 1; i < BF_LATENCY; i++) begin
        r_pipe_en[i]  <= r_pipe_en[i-1];
        r_pipe_cnt[i] <= r_pipe_cnt[i-1];
        r_pipe_stg[i] <= r_pipe_stg[i-1];
      end
    end
  end

  assign o_counter      = r_cnt;
  assign o_stage_num    = r_stg;
  assign o_rd_en        = w_rd_en;
  assign o_wr_en        = r_pipe_en[BF_LATENCY-1];
  assign o_wr_counter   = r_pipe_cnt[BF_LATENCY-1];
  assign o_wr_stage_num = r_pipe_stg[BF_LATENCY-1];
  assign o_busy         = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done         = (r_state == S_DONE);

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Scoreboard bench for fft_stage_sequencer: four builds share start/reset,
// a timing-formula model queues expected reads/writes per build.
module tb_fft_stage_sequencer;

  localparam int NI = 4;
  localparam int P_NS [NI] = '{5, 5, 5, 4};
  localparam int P_L  [NI] = '{2, 1, 4, 2};

  typedef struct {
    int cyc;
    int cnt;
    int stg;
  } ev_t;

  logic clk;
  logic rst;
  logic start;
  logic fin;
  int   cyc;
  int   cmp;
  int   mis;

  logic [7:0] s_cnt  [NI];
  logic [7:0] s_wcnt [NI];
  logic [2:0] s_stg  [NI];
  logic [2:0] s_wstg [NI];
  logic       s_rd   [NI];
  logic       s_wr   [NI];
  logic       s_bsy  [NI];
  logic       s_dn   [NI];

  ev_t rd_q [NI][$];
  ev_t wr_q [NI][$];
  int  b_lo    [NI];
  int  b_hi    [NI];
  int  done_at [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int CW = P_NS[g] - 2;
    logic [CW-1:0] cnt;
    logic [CW-1:0] wcnt;
    logic [2:0]    stg;
    logic [2:0]    wstg;
    logic          rd;
    logic          wr;
    logic          bsy;
    logic          dn;

    fft_stage_sequencer #(
      .NUMSTAGES (P_NS[g]),
      .BF_LATENCY(P_L[g])
    ) u_dut (
      .i_clk         (clk),
      .i_reset       (rst),
      .i_start       (start),
      .o_counter     (cnt),
      .o_stage_num   (stg),
      .o_rd_en       (rd),
      .o_wr_counter  (wcnt),
      .o_wr_stage_num(wstg),
      .o_wr_en       (wr),
      .o_busy        (bsy),
      .o_done        (dn)
    );

    assign s_cnt[g]  = 8'(cnt);
    assign s_wcnt[g] = 8'(wcnt);
    assign s_stg[g]  = stg;
    assign s_wstg[g] = wstg;
    assign s_rd[g]   = rd;
    assign s_wr[g]   = wr;
    assign s_bsy[g]  = bsy;
    assign s_dn[g]   = dn;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Expected schedule of one transform whose start was sampled at end of c0
  task automatic push_run(input int k, input int c0);
    int nb;
    int per;
    nb  = 1 << (P_NS[k] - 2);
    per = nb + P_L[k];
    for (int s = 0; s < P_NS[k]; s++) begin
      for (int i = 0; i < nb; i++) begin
        rd_q[k].push_back('{c0 + 1 + s * per + i, i, s});
        wr_q[k].push_back('{c0 + 1 + s * per + i + P_L[k], i, s});
      end
    end
    b_lo[k]    = c0 + 1;
    b_hi[k]    = c0 + P_NS[k] * per;
    done_at[k] = c0 + P_NS[k] * per + 1;
  endtask

  task automatic step(input logic st, input logic rs);
    @(posedge clk);
    #2;
    rst   = rs;
    start = st;
    for (int k = 0; k < NI; k++) begin
      if (rs) begin
        rd_q[k].delete();
        wr_q[k].delete();
        b_lo[k]    = 0;
        b_hi[k]    = -1;
        done_at[k] = -1;
      end else if (st && cyc > done_at[k]) begin
        push_run(k, cyc);
      end
    end
  endtask

  task automatic chk(input string nm, input int k, input int act, input int exp);
    cmp++;
    if (act != exp) begin
      mis++;
      $display("FAIL %s inst%0d cycle %0d: got %0d expected %0d",
               nm, k, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    for (int k = 0; k < NI; k++) begin
      while (rd_q[k].size() > 0 && rd_q[k][0].cyc < cyc) begin
        chk("rd_missing", k, 0, 1);
        void'(rd_q[k].pop_front());
      end
      while (wr_q[k].size() > 0 && wr_q[k][0].cyc < cyc) begin
        chk("wr_missing", k, 0, 1);
        void'(wr_q[k].pop_front());
      end
      if (s_rd[k]) begin
        if (rd_q[k].size() > 0 && rd_q[k][0].cyc == cyc) begin
          e = rd_q[k].pop_front();
          chk("rd_counter", k, int'(s_cnt[k]), e.cnt);
          chk("rd_stage", k, int'(s_stg[k]), e.stg);
        end else begin
          chk("rd_unexpected", k, 1, 0);
        end
      end
      if (s_wr[k]) begin
        if (wr_q[k].size() > 0 && wr_q[k][0].cyc == cyc) begin
          e = wr_q[k].pop_front();
          chk("wr_counter", k, int'(s_wcnt[k]), e.cnt);
          chk("wr_stage", k, int'(s_wstg[k]), e.stg);
        end else begin
          chk("wr_unexpected", k, 1, 0);
        end
      end
      chk("busy", k, int'(s_bsy[k]), int'(cyc >= b_lo[k] && cyc <= b_hi[k]));
      chk("done", k, int'(s_dn[k]), int'(cyc == done_at[k]));
      if (rst) begin
        chk("rst_zero", k,
            int'((s_cnt[k] | s_wcnt[k]) != 0 || (s_stg[k] | s_wstg[k]) != 0 ||
                 s_rd[k] || s_wr[k] || s_bsy[k] || s_dn[k]), 0);
      end
    end
    if (fin) begin
      for (int k = 0; k < NI; k++) begin
        chk("rd_leftover", k, rd_q[k].size(), 0);
        chk("wr_leftover", k, wr_q[k].size(), 0);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach summary");
    $fatal(1);
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    fin   = 1'b0;
    cyc   = 0;
    cmp   = 0;
    mis   = 0;
    for (int k = 0; k < NI; k++) begin
      b_lo[k]    = 0;
      b_hi[k]    = -1;
      done_at[k] = -1;
    end
    repeat (3) step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);

    // single start plus pulses that must be ignored while running
    step(1'b1, 1'b0);
    for (int i = 1; i <= 60; i++) begin
      step(i == 5 || i == 20 || i == 51, 1'b0);
    end
    repeat (70) step(1'b0, 1'b0);

    // start held high across DONE
    repeat (60) step(1'b1, 1'b0);
    repeat (130) step(1'b0, 1'b0);

    // reset in the middle of stage 2, then a clean run
    step(1'b1, 1'b0);
    repeat (24) step(1'b0, 1'b0);
    repeat (3) step(1'b0, 1'b1);
    repeat (2) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    repeat (70) step(1'b0, 1'b0);

    // random start/reset traffic
    repeat (400) begin
      step(($urandom % 10) == 0, ($urandom % 150) == 0);
    end
    repeat (70) step(1'b0, 1'b0);

    @(posedge clk);
    #2;
    fin = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL monitor did not close the run");
    $fatal(1);
  end

endmodule
